// File: rtl/adder_rs_scheduler.sv
// Adder reservation-station scheduler: owns NUM_RS stations, tracks operand
// tags, wakes stations from the CDB and from the adder's own completion, and
// round-robin dispatches one READY station at a time to a non-pipelined adder.

// One reservation station: FREE -> WAIT | READY -> EXEC -> FREE.
module adder_rs_entry #(
  parameter int NUM_RS    = 6,
  parameter int OP_BITS   = 6,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 alloc,       // load this station on this edge
  input  logic [OP_BITS-1:0]   alloc_op,
  input  logic [ADDR_BITS-1:0] alloc_dest,
  input  logic [NUM_RS-1:0]    alloc_a,     // already masked by same-cycle wakeups
  input  logic [NUM_RS-1:0]    alloc_b,
  input  logic [NUM_RS-1:0]    wake,        // tags broadcast this cycle
  input  logic                 grant,       // dispatched to the adder
  input  logic                 finish,      // adder reported completion
  output logic                 is_free,
  output logic                 is_ready,
  output logic                 is_exec,
  output logic [OP_BITS-1:0]   op_o,
  output logic [ADDR_BITS-1:0] dest_o
);
  localparam logic [1:0] S_FREE = 2'd0, S_WAIT = 2'd1, S_READY = 2'd2, S_EXEC = 2'd3;

  logic [1:0]           st_q, st_d;
  logic [NUM_RS-1:0]    a_q, a_d, b_q, b_d;
  logic [OP_BITS-1:0]   op_q, op_d;
  logic [ADDR_BITS-1:0] dest_q, dest_d;

  // Station state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= S_FREE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      dest_q <= '0;
    end else begin
      st_q   <= st_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      dest_q <= dest_d;
    end
  end

  // Tag wakeup every cycle; state moves on allocate, wakeup, grant and finish.
  always_comb begin
    st_d   = st_q;
    a_d    = a_q & ~wake;
    b_d    = b_q & ~wake;
    op_d   = op_q;
    dest_d = dest_q;
    case (st_q)
      S_FREE: if (alloc) begin
        op_d   = alloc_op;
        dest_d = alloc_dest;
        a_d    = alloc_a;
        b_d    = alloc_b;
        st_d   = (|alloc_a || |alloc_b) ? S_WAIT : S_READY;
      end
      S_WAIT:  if (a_d == '0 && b_d == '0) st_d = S_READY;
      S_READY: if (grant) st_d = S_EXEC;
      default: if (finish) st_d = S_FREE;
    endcase
  end

  assign is_free  = (st_q == S_FREE);
  assign is_ready = (st_q == S_READY);
  assign is_exec  = (st_q == S_EXEC);
  assign op_o     = op_q;
  assign dest_o   = dest_q;
endmodule

module adder_rs_scheduler #(
  parameter int NUM_RS    = 6,
  parameter int OP_BITS   = 6,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 issue,
  input  logic [OP_BITS-1:0]   operation,
  input  logic [ADDR_BITS-1:0] Dest_address,
  input  logic [NUM_RS-1:0]    A_tag,
  input  logic [NUM_RS-1:0]    B_tag,
  input  logic                 cdb_valid,
  input  logic [NUM_RS-1:0]    cdb_tag,
  input  logic                 adder_rts,
  output logic                 adder_available,
  output logic [NUM_RS-1:0]    adder_RS_available,
  output logic                 issue_error,
  output logic [NUM_RS-1:0]    RS_issued,
  output logic [NUM_RS-1:0]    RS_executing_adder,
  output logic [NUM_RS-1:0]    RS_finished,
  output logic                 adder_start,
  output logic [OP_BITS-1:0]   adder_op,
  output logic [ADDR_BITS-1:0] adder_dest
);
  localparam int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic {IDLE, BUSY} fsm_e;

  fsm_e                              fsm_q, fsm_d;
  logic [PW-1:0]                     rr_q, rr_d;
  logic [NUM_RS-1:0]                 free_v, ready_v, exec_v;
  logic [NUM_RS-1:0][OP_BITS-1:0]    op_v;
  logic [NUM_RS-1:0][ADDR_BITS-1:0]  dest_v;
  logic [NUM_RS-1:0]                 avail_oh, alloc_v, fin_v, wake_v, grant_v;
  logic [NUM_RS-1:0]                 alloc_a, alloc_b;
  logic [PW-1:0]                     grant_idx;
  logic                              grant_found;
  int                                scan_idx;

  logic                 start_q, start_d, err_q, err_d;
  logic [NUM_RS-1:0]    issued_q, issued_d, exe_q, exe_d, fin_q, fin_d;
  logic [OP_BITS-1:0]   op_q, op_d;
  logic [ADDR_BITS-1:0] dest_q, dest_d;

  // Lowest free station: isolate the lowest set bit of the free vector.
  assign avail_oh = free_v & (~free_v + {{(NUM_RS-1){1'b0}}, 1'b1});
  assign alloc_v  = issue ? avail_oh : '0;
  assign fin_v    = (fsm_q == BUSY && adder_rts) ? exec_v : '0;
  assign wake_v   = (cdb_valid ? cdb_tag : '0) | fin_v;
  // A tag produced this very cycle is already satisfied when it is stored.
  assign alloc_a  = A_tag & ~wake_v;
  assign alloc_b  = B_tag & ~wake_v;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
    adder_rs_entry #(.NUM_RS(NUM_RS), .OP_BITS(OP_BITS), .ADDR_BITS(ADDR_BITS)) u_rs (
      .clock      (clock),
      .reset_n    (reset_n),
      .alloc      (alloc_v[i]),
      .alloc_op   (operation),
      .alloc_dest (Dest_address),
      .alloc_a    (alloc_a),
      .alloc_b    (alloc_b),
      .wake       (wake_v),
      .grant      (grant_v[i]),
      .finish     (fin_v[i]),
      .is_free    (free_v[i]),
      .is_ready   (ready_v[i]),
      .is_exec    (exec_v[i]),
      .op_o       (op_v[i]),
      .dest_o     (dest_v[i])
    );
  end

  // Round-robin pick: first READY station at or after rr, wrapping.
  always_comb begin
    grant_v     = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_RS; k++) begin
      scan_idx = (int'(rr_q) + k) % NUM_RS;
      if (!grant_found && ready_v[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(scan_idx);
      end
    end
    if (fsm_q == IDLE && grant_found) grant_v[grant_idx] = 1'b1;
  end

  // Adder FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  // Adder FSM next state: launch on a grant, return to IDLE on completion.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (|grant_v) fsm_d = BUSY;
      default: if (adder_rts) fsm_d = IDLE;
    endcase
  end

  // Registered-output next values; op/dest hold until the next launch.
  always_comb begin
    start_d  = |grant_v;
    exe_d    = grant_v;
    fin_d    = fin_v;
    issued_d = alloc_v;
    err_d    = issue && !(|free_v);
    op_d     = op_q;
    dest_d   = dest_q;
    rr_d     = rr_q;
    if (|grant_v) begin
      op_d   = op_v[grant_idx];
      dest_d = dest_v[grant_idx];
      rr_d   = (grant_idx == PW'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Output pulses, held adder fields and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      issued_q <= '0;
      exe_q    <= '0;
      fin_q    <= '0;
      op_q     <= '0;
      dest_q   <= '0;
      rr_q     <= '0;
    end else begin
      start_q  <= start_d;
      err_q    <= err_d;
      issued_q <= issued_d;
      exe_q    <= exe_d;
      fin_q    <= fin_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      rr_q     <= rr_d;
    end
  end

  assign adder_available    = |free_v;
  assign adder_RS_available = avail_oh;
  assign issue_error        = err_q;
  assign RS_issued          = issued_q;
  assign RS_executing_adder = exe_q;
  assign RS_finished        = fin_q;
  assign adder_start        = start_q;
  assign adder_op           = op_q;
  assign adder_dest         = dest_q;
endmodule
